// File: rtl/round_scorekeeper_pkg.sv
// Shared state and winner encodings for the two-player number game sequencer.
package round_scorekeeper_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P1_ENTRY  = 3'd1,
        P2_ENTRY  = 3'd2,
        COMPARE   = 3'd3,
        AWARD     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;

endpackage

// File: rtl/round_scorekeeper_rise_pulse.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level first reads 1.
module rise_pulse (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/round_scorekeeper.sv
// Round sequencer: latches both players' entries, compares them, keeps scores and
// forfeits a round when the active player stalls for TIMEOUT_CYC cycles.
module round_scorekeeper
    import round_scorekeeper_pkg::*;
#(
    parameter int NUM_W       = 8,
    parameter int SCORE_W     = 2,
    parameter int WIN_SCORE   = 2,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_p1,
    input  logic               btn_p2,
    input  logic               btn_mid,
    input  logic [NUM_W-1:0]   sw_number,
    output logic [NUM_W-1:0]   p1_number,
    output logic [NUM_W-1:0]   p2_number,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [2:0]         phase,
    output logic               round_done,
    output logic               tie,
    output logic [1:0]         round_winner,
    output logic               game_over
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= SCORE_W'(WIN_SCORE)) ? s : s + SCORE_W'(1);
    endfunction

    state_t             state_q, state_d;
    winner_t            pend_win_q, pend_d, round_winner_q;
    logic [TMR_W-1:0]   timer_q;
    logic [NUM_W-1:0]   p1_number_q, p2_number_q;
    logic [SCORE_W-1:0] p1_score_q, p2_score_q, award_score;
    logic               p1_press, p2_press, mid_press, timeout;
    logic               latch_p1, latch_p2, load_pend, award, do_tie, clear;
    logic               round_done_q, tie_q;

    rise_pulse u_rise_p1  (.clk(clk), .reset(reset), .level(btn_p1),  .pulse(p1_press));
    rise_pulse u_rise_p2  (.clk(clk), .reset(reset), .level(btn_p2),  .pulse(p2_press));
    rise_pulse u_rise_mid (.clk(clk), .reset(reset), .level(btn_mid), .pulse(mid_press));

    assign timeout     = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign award_score = (pend_win_q == WIN_P1) ? sat_inc(p1_score_q) : sat_inc(p2_score_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Presses not matching the current state are simply dropped; a press beats a timeout.
    always_comb begin
        state_d   = state_q;
        latch_p1  = 1'b0;
        latch_p2  = 1'b0;
        load_pend = 1'b0;
        pend_d    = WIN_NONE;
        award     = 1'b0;
        do_tie    = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: if (mid_press) state_d = P1_ENTRY;
            P1_ENTRY: begin
                if (p1_press) begin
                    latch_p1 = 1'b1;
                    state_d  = P2_ENTRY;
                end else if (timeout) begin
                    load_pend = 1'b1;
                    pend_d    = WIN_P2;
                    state_d   = AWARD;
                end
            end
            P2_ENTRY: begin
                if (p2_press) begin
                    latch_p2 = 1'b1;
                    state_d  = COMPARE;
                end else if (timeout) begin
                    load_pend = 1'b1;
                    pend_d    = WIN_P1;
                    state_d   = AWARD;
                end
            end
            COMPARE: begin
                if (p1_number_q > p2_number_q) begin
                    load_pend = 1'b1;
                    pend_d    = WIN_P1;
                    state_d   = AWARD;
                end else if (p1_number_q < p2_number_q) begin
                    load_pend = 1'b1;
                    pend_d    = WIN_P2;
                    state_d   = AWARD;
                end else begin
                    do_tie  = 1'b1;
                    state_d = P1_ENTRY;
                end
            end
            AWARD: begin
                award   = 1'b1;
                state_d = (award_score == SCORE_W'(WIN_SCORE)) ? GAME_OVER : P1_ENTRY;
            end
            GAME_OVER: begin
                if (mid_press) begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q        <= '0;
            p1_number_q    <= '0;
            p2_number_q    <= '0;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            pend_win_q     <= WIN_NONE;
            round_winner_q <= WIN_NONE;
            round_done_q   <= 1'b0;
            tie_q          <= 1'b0;
        end else begin
            round_done_q <= award;
            tie_q        <= do_tie;
            // Timer restarts on every state change so each entry state gets a full window.
            if (state_d != state_q)
                timer_q <= '0;
            else if (state_q == P1_ENTRY || state_q == P2_ENTRY)
                timer_q <= timer_q + TMR_W'(1);
            if (clear) begin
                p1_number_q    <= '0;
                p2_number_q    <= '0;
                p1_score_q     <= '0;
                p2_score_q     <= '0;
                pend_win_q     <= WIN_NONE;
                round_winner_q <= WIN_NONE;
            end else begin
                if (latch_p1)  p1_number_q <= sw_number;
                if (latch_p2)  p2_number_q <= sw_number;
                if (load_pend) pend_win_q  <= pend_d;
                if (award) begin
                    round_winner_q <= pend_win_q;
                    if (pend_win_q == WIN_P1)      p1_score_q <= award_score;
                    else if (pend_win_q == WIN_P2) p2_score_q <= award_score;
                end
            end
        end
    end

    assign p1_number    = p1_number_q;
    assign p2_number    = p2_number_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign phase        = state_q;
    assign round_done   = round_done_q;
    assign tie          = tie_q;
    assign round_winner = round_winner_q;
    assign game_over    = (state_q == GAME_OVER);

endmodule

// File: tb/tb_round_scorekeeper.sv
// Directed bench for round_scorekeeper with a scoreboard of expected round/tie events.
module tb_round_scorekeeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_p1, btn_p2, btn_mid;
    logic [7:0] sw_number;
    logic [7:0] p1_number, p2_number;
    logic [1:0] p1_score, p2_score;
    logic [2:0] phase;
    logic       round_done, tie, game_over;
    logic [1:0] round_winner;

    typedef struct {
        bit         is_tie;
        logic [1:0] win;
        logic [1:0] s1;
        logic [1:0] s2;
    } exp_t;

    exp_t exp_q[$];
    exp_t ev;
    int   tests = 0;
    int   fails = 0;
    int   fcyc;

    round_scorekeeper #(
        .NUM_W(8), .SCORE_W(2), .WIN_SCORE(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_p1(btn_p1), .btn_p2(btn_p2), .btn_mid(btn_mid),
        .sw_number(sw_number),
        .p1_number(p1_number), .p2_number(p2_number),
        .p1_score(p1_score), .p2_score(p2_score),
        .phase(phase), .round_done(round_done), .tie(tie),
        .round_winner(round_winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_tie, input logic [1:0] win, input logic [1:0] s1,
                        input logic [1:0] s2);
        exp_t e;
        e.is_tie = is_tie;
        e.win    = win;
        e.s1     = s1;
        e.s2     = s2;
        exp_q.push_back(e);
    endtask

    // which: 0 = mid, 1 = p1, 2 = p2
    task automatic press(input int which, input logic [7:0] val);
        sw_number = val;
        case (which)
            0: btn_mid = 1'b1;
            1: btn_p1  = 1'b1;
            default: btn_p2 = 1'b1;
        endcase
        repeat (2) @(negedge clk);
        btn_mid = 1'b0;
        btn_p1  = 1'b0;
        btn_p2  = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_p1num"}, 32'(p1_number), 32'h0);
        check({tag, "_p2num"}, 32'(p2_number), 32'h0);
        check({tag, "_p1sc"},  32'(p1_score), 32'h0);
        check({tag, "_p2sc"},  32'(p2_score), 32'h0);
        check({tag, "_phase"}, 32'(phase), 32'h0);
        check({tag, "_win"},   32'(round_winner), 32'h0);
        check({tag, "_go"},    32'(game_over), 32'h0);
        check({tag, "_done"},  32'(round_done), 32'h0);
        check({tag, "_tie"},   32'(tie), 32'h0);
    endtask

    always @(negedge clk) begin
        if (!reset && (round_done || tie)) begin
            check("done_tie_exclusive", 32'(round_done & tie), 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(round_done), 32'h0);
                check("unexpected_tie", 32'(tie), 32'h0);
            end else begin
                ev = exp_q.pop_front();
                check("event_kind", 32'(tie), 32'(ev.is_tie));
                check("event_winner", 32'(round_winner), 32'(ev.win));
                check("event_p1_score", 32'(p1_score), 32'(ev.s1));
                check("event_p2_score", 32'(p2_score), 32'(ev.s2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; btn_p1 = 1'b0; btn_p2 = 1'b0; btn_mid = 1'b0; sw_number = 8'h00;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Round 1: P1 wins 0x40 vs 0x20
        press(0, 8'h00);
        check("start_phase", 32'(phase), 32'd1);
        press(1, 8'h40);
        check("p1_latched_phase", 32'(phase), 32'd2);
        push(1'b0, 2'b01, 2'd1, 2'd0);
        press(2, 8'h20);
        repeat (2) @(negedge clk);
        check("r1_p1num", 32'(p1_number), 32'h40);
        check("r1_p2num", 32'(p2_number), 32'h20);
        check("r1_winner", 32'(round_winner), 32'h1);
        check("r1_p1sc", 32'(p1_score), 32'd1);
        check("r1_phase", 32'(phase), 32'd1);

        // Round 2: tie
        push(1'b1, 2'b01, 2'd1, 2'd0);
        press(1, 8'h05);
        press(2, 8'h05);
        repeat (2) @(negedge clk);
        check("tie_phase", 32'(phase), 32'd1);
        check("tie_p1sc", 32'(p1_score), 32'd1);
        check("tie_p2sc", 32'(p2_score), 32'd0);

        // Rounds 3 and 4: P2 wins twice, game over
        push(1'b0, 2'b10, 2'd1, 2'd1);
        press(1, 8'h10);
        press(2, 8'h90);
        repeat (2) @(negedge clk);
        check("r3_p2sc", 32'(p2_score), 32'd1);
        push(1'b0, 2'b10, 2'd1, 2'd2);
        press(1, 8'h01);
        press(2, 8'hFF);
        repeat (2) @(negedge clk);
        check("go_phase", 32'(phase), 32'd5);
        check("go_flag", 32'(game_over), 32'd1);
        check("go_p2sc", 32'(p2_score), 32'd2);
        check("go_p1sc", 32'(p1_score), 32'd1);
        press(0, 8'h00);
        check_all_zero("clear");

        // Timeout forfeit in P1_ENTRY
        press(0, 8'h00);
        sw_number = 8'hAA;
        push(1'b0, 2'b10, 2'd0, 2'd1);
        fcyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (phase == 3'd4) begin
                fcyc = i;
                break;
            end
        end
        check("forfeit_cycle", 32'(fcyc), 32'd15);
        @(negedge clk);
        check("forfeit_phase", 32'(phase), 32'd1);
        check("forfeit_p2sc", 32'(p2_score), 32'd1);
        check("forfeit_p1num", 32'(p1_number), 32'h0);

        // Press landing in the last entry cycle is accepted
        repeat (14) @(negedge clk);
        sw_number = 8'h33;
        btn_p1 = 1'b1;
        @(negedge clk);
        check("last_cycle_phase", 32'(phase), 32'd1);
        @(negedge clk);
        check("late_press_phase", 32'(phase), 32'd2);
        check("late_press_p1num", 32'(p1_number), 32'h33);
        btn_p1 = 1'b0;
        @(negedge clk);
        push(1'b0, 2'b01, 2'd1, 2'd1);
        press(2, 8'h10);
        repeat (2) @(negedge clk);
        check("r5_p1sc", 32'(p1_score), 32'd1);

        // Simultaneous p1/p2 rise in P1_ENTRY; held p2 must not replay
        sw_number = 8'h77;
        btn_p1 = 1'b1;
        btn_p2 = 1'b1;
        repeat (2) @(negedge clk);
        check("simul_phase", 32'(phase), 32'd2);
        check("simul_p1num", 32'(p1_number), 32'h77);
        check("simul_p2num", 32'(p2_number), 32'h10);
        btn_p1 = 1'b0;
        repeat (5) @(negedge clk);
        check("held_phase", 32'(phase), 32'd2);
        check("held_p2num", 32'(p2_number), 32'h10);
        btn_p2 = 1'b0;
        @(negedge clk);
        push(1'b0, 2'b10, 2'd1, 2'd2);
        press(2, 8'h80);
        repeat (2) @(negedge clk);
        check("r6_phase", 32'(phase), 32'd5);
        check("r6_p2num", 32'(p2_number), 32'h80);
        press(0, 8'h00);

        // Reset mid-round in P2_ENTRY
        press(0, 8'h00);
        press(1, 8'h21);
        push(1'b0, 2'b01, 2'd1, 2'd0);
        press(2, 8'h20);
        repeat (2) @(negedge clk);
        check("pre_rst_p1sc", 32'(p1_score), 32'd1);
        press(1, 8'h50);
        check("pre_rst_phase", 32'(phase), 32'd2);
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_phase", 32'(phase), 32'd0);
        check("post_rst_p1sc", 32'(p1_score), 32'd0);
        check("events_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
